// File: rtl/config_loader_pkg.sv
`default_nettype none
// config_loader_pkg: shared loader FSM states and chain length so loader and fabric agree.
// Rev 1.0
package config_loader_pkg;

  localparam int CHAIN_LEN_DEFAULT = 1040;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SHIFT = 3'd2,
    FLUSH = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/config_word_fifo.sv
`default_nettype none
// config_word_fifo: synchronous DATA_W x DEPTH word FIFO, same-cycle push/pop, full/empty flags.
// Rev 1.0
module config_word_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// config_loader: serialises a word stream MSB-first into the fabric config chain, then latches it.
// Optional readback of the previous chain contents: CONFIG_LOADER_READBACK_EN. Rev 1.0
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEFAULT,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              config_clk,
  input  logic              sys_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              config_in,
  output logic              config_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef CONFIG_LOADER_READBACK_EN
  ,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid
`endif
);

  localparam int NWORDS = ceil_div(CHAIN_LEN, DATA_W);
  localparam int BIT_W  = $clog2(CHAIN_LEN);
  localparam int WB_W   = $clog2(DATA_W);
  localparam int WRX_W  = $clog2(NWORDS + 1);

  state_e            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   wbit;
  logic [WRX_W-1:0]  words_rx;
  logic [DATA_W-1:0] shreg;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              start_acc;
  logic              rx_open;
  logic              fill_done;
  logic              last_bit;
  logic              at_boundary;

  assign start_acc   = start && (state == IDLE);
  assign rx_open     = (words_rx != WRX_W'(NWORDS));
  assign fill_done   = (state == FILL) && (fifo_full || !rx_open);
  assign last_bit    = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
  assign at_boundary = (wbit == WB_W'(DATA_W - 1));

  // Words arriving during FLUSH are acknowledged but never stored.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      FILL, SHIFT: s_ready = !fifo_full && rx_open;
      FLUSH:       s_ready = 1'b1;
      default:     s_ready = 1'b0;
    endcase
  end

  assign fifo_push = s_valid && s_ready && ((state == FILL) || (state == SHIFT));
  assign fifo_pop  = fill_done ||
                     ((state == SHIFT) && !last_bit && at_boundary && !fifo_empty);

  config_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (config_clk),
    .rst   (sys_reset),
    .clear (start_acc),
    .push  (fifo_push),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge config_clk) begin
    if (sys_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      wbit      <= '0;
      words_rx  <= '0;
      shreg     <= '0;
      config_in <= 1'b0;
      config_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            error    <= 1'b0;
            bit_cnt  <= '0;
            wbit     <= '0;
            words_rx <= '0;
          end
        end
        FILL: begin
          if (fifo_push) words_rx <= words_rx + WRX_W'(1);
          // The first bit goes out on the same edge that leaves FILL.
          if (fill_done) begin
            state     <= SHIFT;
            config_en <= 1'b1;
            config_in <= fifo_rdata[DATA_W-1];
            shreg     <= {fifo_rdata[DATA_W-2:0], 1'b0};
            bit_cnt   <= '0;
            wbit      <= '0;
          end
        end
        SHIFT: begin
          if (fifo_push) words_rx <= words_rx + WRX_W'(1);
          if (last_bit) begin
            state     <= LATCH;
            config_en <= 1'b0;
            config_in <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (at_boundary) begin
              wbit <= '0;
              if (!fifo_empty) begin
                config_in <= fifo_rdata[DATA_W-1];
                shreg     <= {fifo_rdata[DATA_W-2:0], 1'b0};
              end else begin
                // Underflow: restart the count and blank the whole chain.
                state     <= FLUSH;
                error     <= 1'b1;
                config_in <= 1'b0;
                bit_cnt   <= '0;
              end
            end else begin
              config_in <= shreg[DATA_W-1];
              shreg     <= {shreg[DATA_W-2:0], 1'b0};
              wbit      <= wbit + WB_W'(1);
            end
          end
        end
        FLUSH: begin
          config_in <= 1'b0;
          if (last_bit) begin
            state     <= LATCH;
            config_en <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        LATCH: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_LOADER_READBACK_EN
  logic [DATA_W-1:0] rb_word;
  logic [DATA_W-1:0] rb_next;
  logic [WB_W-1:0]   rb_cnt;

  assign rb_next = {rb_word[DATA_W-2:0], chain_tail};

  always_ff @(posedge config_clk) begin
    if (sys_reset) begin
      rb_word <= '0;
      rb_cnt  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (start_acc) begin
        rb_cnt <= '0;
      end else if (config_en) begin
        rb_word <= rb_next;
        if (rb_cnt == WB_W'(DATA_W - 1)) begin
          m_data  <= rb_next;
          m_valid <= 1'b1;
          rb_cnt  <= '0;
        end else begin
          rb_cnt <= rb_cnt + WB_W'(1);
        end
      end else if ((state == LATCH) && (rb_cnt != '0)) begin
        // Left-align the leftover bits; the stale upper bits shift out.
        m_data  <= rb_word << (DATA_W - int'(rb_cnt));
        m_valid <= 1'b1;
        rb_cnt  <= '0;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = chain_tail;
`endif

endmodule
`default_nettype wire
